image_crop_stream: RTL and testbench

Streaming crop stage feeding the `myproject` network input. It consumes a full IN_ROWS×IN_COLS raster-order pixel stream (AXI-Stream style TVALID/TREADY), forwards only the OUT_ROWS×OUT_COLS window whose top-left corner is at (Y_1, X_1), and discards every other pixel. It is controlled by the ap_start/ap_done/ap_idle/ap_ready block-level protocol. Its output drives `conv2d_input_V_data_0_V_*` directly.

---
 rtl/image_crop_stream_if.sv | 12 +
 rtl/image_crop_stream.sv | 150 +++++++++++++++
 tb/tb_image_crop_stream.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/image_crop_stream_if.sv
// AXI-Stream style pixel channel (TDATA/TVALID/TREADY) shared by the crop
// stage's input and output ports.
interface image_crop_stream_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] TDATA;
  logic              TVALID;
  logic              TREADY;

  modport master (output TDATA, output TVALID, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/image_crop_stream.sv
// Streaming crop: forwards the OUT_ROWS x OUT_COLS window of a raster frame.
// Optional CROP_ORIGIN_PORT_EN: runtime origin via crop_y1/crop_x1, clamped.
module image_crop_stream #(
  parameter int DATA_W   = 16,
  parameter int IN_ROWS  = 100,
  parameter int IN_COLS  = 160,
  parameter int OUT_ROWS = 48,
  parameter int OUT_COLS = 48,
  parameter int Y_1      = 10,
  parameter int X_1      = 10
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  output logic                        ap_done,
  output logic                        ap_idle,
  output logic                        ap_ready,
`ifdef CROP_ORIGIN_PORT_EN
  input  logic [$clog2(IN_ROWS)-1:0]  crop_y1,
  input  logic [$clog2(IN_COLS)-1:0]  crop_x1,
`endif
  image_crop_stream_if.slave          img_in_V_data_0_V,
  image_crop_stream_if.master         conv2d_input_V_data_0_V
);

  localparam int ROW_W = $clog2(IN_ROWS);
  localparam int COL_W = $clog2(IN_COLS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_y1;
  logic [COL_W-1:0]    r_x1;
  logic [ROW_W-1:0]    w_y1_src;
  logic [COL_W-1:0]    w_x1_src;
  logic [ROW_W-1:0]    w_row_off;
  logic [COL_W-1:0]    w_col_off;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_ap_ready;
  logic                w_in_win;
  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_load;
  logic                w_out_fire;
  logic                w_last_px;
  logic                w_col_wrap;

`ifdef CROP_ORIGIN_PORT_EN
  localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(IN_ROWS - OUT_ROWS);
  localparam logic [COL_W-1:0] X_MAX = COL_W'(IN_COLS - OUT_COLS);
  assign w_y1_src = (crop_y1 > Y_MAX) ? Y_MAX : crop_y1;
  assign w_x1_src = (crop_x1 > X_MAX) ? X_MAX : crop_x1;
`else
  assign w_y1_src = ROW_W'(Y_1);
  assign w_x1_src = COL_W'(X_1);
`endif

  // Offsets only meaningful once row>=y1 and col>=x1; the extra MSB keeps
  // the compare against OUT_* exact even when the window spans the frame.
  assign w_row_off = r_row - r_y1;
  assign w_col_off = r_col - r_x1;
  assign w_in_win  = (r_row >= r_y1) && (r_col >= r_x1) &&
                     ({1'b0, w_row_off} < (ROW_W+1)'(OUT_ROWS)) &&
                     ({1'b0, w_col_off} < (COL_W+1)'(OUT_COLS));

  assign w_col_wrap = (r_col == COL_W'(IN_COLS - 1));
  assign w_last_px  = w_col_wrap && (r_row == ROW_W'(IN_ROWS - 1));
  assign w_out_fire = r_out_valid && conv2d_input_V_data_0_V.TREADY;
  assign w_in_fire  = img_in_V_data_0_V.TVALID && w_in_ready;
  assign w_load     = w_in_fire && w_in_win;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ap_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_in_ready = w_in_win ? (!r_out_valid || conv2d_input_V_data_0_V.TREADY) : 1'b1;
        if (img_in_V_data_0_V.TVALID && w_in_ready && w_last_px) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_out_valid || conv2d_input_V_data_0_V.TREADY) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_y1       <= '0;
      r_x1       <= '0;
      r_ap_ready <= 1'b0;
    end else begin
      r_ap_ready <= (r_state == S_IDLE) && ap_start;
      if ((r_state == S_IDLE) && ap_start) begin
        r_row <= '0;
        r_col <= '0;
        r_y1  <= w_y1_src;
        r_x1  <= w_x1_src;
      end else if (w_in_fire) begin
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= w_last_px ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // A load in the same cycle as a drain keeps TVALID high.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= img_in_V_data_0_V.TDATA;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign ap_done  = (r_state == S_DONE);
  assign ap_idle  = (r_state == S_IDLE);
  assign ap_ready = r_ap_ready;

  assign img_in_V_data_0_V.TREADY        = w_in_ready;
  assign conv2d_input_V_data_0_V.TDATA  = r_out_data;
  assign conv2d_input_V_data_0_V.TVALID = r_out_valid;

endmodule

// File: tb/tb_image_crop_stream.sv
// Self-checking bench for image_crop_stream: ramp frames, random stalls,
// drain hold, ignored mid-frame start and asynchronous reset mid-frame.
module tb_image_crop_stream;

  localparam int DATA_W   = 16;
  localparam int IN_ROWS  = 100;
  localparam int IN_COLS  = 160;
  localparam int OUT_ROWS = 48;
  localparam int OUT_COLS = 48;
  localparam int NPIX     = IN_ROWS * IN_COLS;
  localparam int NOUT     = OUT_ROWS * OUT_COLS;
`ifdef CROP_ORIGIN_PORT_EN
  localparam int EY = 52;
  localparam int EX = 112;
  logic [6:0] crop_y1 = 7'd60;
  logic [7:0] crop_x1 = 8'd150;
`else
  localparam int EY = 10;
  localparam int EX = 10;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  logic ap_start;
  logic ap_done;
  logic ap_idle;
  logic ap_ready;

  image_crop_stream_if #(.DATA_W(DATA_W)) in_if ();
  image_crop_stream_if #(.DATA_W(DATA_W)) out_if ();

  image_crop_stream #(
    .DATA_W(DATA_W), .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS),
    .OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS), .Y_1(10), .X_1(10)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .ap_idle(ap_idle),
    .ap_ready(ap_ready),
`ifdef CROP_ORIGIN_PORT_EN
    .crop_y1(crop_y1),
    .crop_x1(crop_x1),
`endif
    .img_in_V_data_0_V(in_if),
    .conv2d_input_V_data_0_V(out_if)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    string name;
    int    idx;
    int    exp;
  } vec_t;
  vec_t tbl[6];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int q[$];
  int last_beat_cyc = 0;
  int last_in_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int ready_cnt = 0;
  int stall_viol = 0;
  bit prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int exp_pix(input int i);
    return (EY + i / OUT_COLS) * IN_COLS + EX + i % OUT_COLS;
  endfunction

  // Observe at the falling edge; inputs change only #1 after rising edges.
  always @(negedge ap_clk) begin
    cyc++;
    if (!ap_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_if.TVALID || out_if.TDATA != prev_data)) stall_viol++;
      prev_stall = out_if.TVALID && !out_if.TREADY;
      prev_data  = out_if.TDATA;
      if (out_if.TVALID && out_if.TREADY) begin
        q.push_back(int'(out_if.TDATA));
        last_beat_cyc = cyc;
      end
      if (in_if.TVALID && in_if.TREADY) last_in_cyc = cyc;
      if (ap_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ap_ready) ready_cnt++;
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic start_frame();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
  endtask

  task automatic run_pixels(input bit rnd_in, input bit rnd_out, input bit hold_last,
                            input int max_pix, input int start_at);
    int p = 0;
    int budget = 60000;
    bit acc;
    while (p < max_pix && budget > 0) begin
      in_if.TVALID  = rnd_in ? 1'($urandom % 2) : 1'b1;
      in_if.TDATA   = DATA_W'(p);
      ap_start      = (p == start_at);
      out_if.TREADY = (hold_last && q.size() >= NOUT - 1) ? 1'b0 :
                      (rnd_out ? 1'($urandom % 2) : 1'b1);
      @(negedge ap_clk);
      acc = in_if.TVALID && in_if.TREADY;
      tick();
      if (acc) p++;
      budget--;
    end
    if (budget == 0) check("pixel_budget", p, max_pix);
    in_if.TVALID = 1'b0;
    ap_start     = 1'b0;
  endtask

  task automatic wait_done(input int prev_cnt);
    int n = 0;
    while (done_cnt == prev_cnt && n < 50) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt, prev_cnt + 1);
  endtask

  task automatic check_frame(input string tag);
    int bad = 0;
    check({tag, "_count"}, q.size(), NOUT);
    for (int i = 0; i < q.size() && i < NOUT; i++)
      if (q[i] != exp_pix(i)) bad++;
    check({tag, "_seq_errs"}, bad, 0);
    for (int k = 0; k < 6; k++) begin
      if (tbl[k].idx < q.size()) check({tag, "_", tbl[k].name}, q[tbl[k].idx], tbl[k].exp);
      else                       check({tag, "_", tbl[k].name}, -1, tbl[k].exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ap_idle"},  int'(ap_idle), 1);
    check({tag, "_ap_done"},  int'(ap_done), 0);
    check({tag, "_ap_ready"}, int'(ap_ready), 0);
    check({tag, "_in_tready"}, int'(in_if.TREADY), 0);
    check({tag, "_out_tvalid"}, int'(out_if.TVALID), 0);
    check({tag, "_out_tdata"}, int'(out_if.TDATA), 0);
  endtask

  initial begin
`ifdef CROP_ORIGIN_PORT_EN
    tbl[0] = '{"first", 0, 8432};
    tbl[1] = '{"idx47", 47, 8479};
    tbl[2] = '{"idx48", 48, 8592};
    tbl[3] = '{"idx100", 100, 8756};
    tbl[4] = '{"idx1151", 1151, 12159};
    tbl[5] = '{"last", 2303, 15999};
`else
    tbl[0] = '{"first", 0, 1610};
    tbl[1] = '{"idx47", 47, 1657};
    tbl[2] = '{"idx48", 48, 1770};
    tbl[3] = '{"idx100", 100, 1934};
    tbl[4] = '{"idx1151", 1151, 5337};
    tbl[5] = '{"last", 2303, 9177};
`endif

    ap_rst_n      = 1'b1;
    ap_start      = 1'b0;
    in_if.TVALID  = 1'b0;
    in_if.TDATA   = '0;
    out_if.TREADY = 1'b0;
    #1 ap_rst_n = 1'b0;
    #11;
    check_reset_vals("rst");
    tick();
    ap_rst_n = 1'b1;
    tick();

    // Frame A: full speed, with an ap_start pulse in mid-frame.
    q.delete();
    start_frame();
    check("A_ap_ready", int'(ap_ready), 1);
    check("A_ap_idle_run", int'(ap_idle), 0);
    run_pixels(1'b0, 1'b0, 1'b0, NPIX, 8000);
    wait_done(0);
    check_frame("A");
    check("A_done_after_last_in", done_cyc - last_in_cyc, 2);
    check("A_ready_cnt", ready_cnt, 1);
    check("A_idle_after", int'(ap_idle), 1);

    // Frame B: back to back, random input valid and output ready.
    q.delete();
    stall_viol = 0;
    start_frame();
    run_pixels(1'b1, 1'b1, 1'b0, NPIX, -1);
    wait_done(1);
    check_frame("B");
    check("B_stall_stable", stall_viol, 0);
    check("B_ready_cnt", ready_cnt, 2);

    // Frame C: aborted by reset after 5000 pixels.
    q.delete();
    start_frame();
    run_pixels(1'b0, 1'b0, 1'b0, 5000, -1);
    check("C_pre_valid", int'(out_if.TVALID), 1);
    #2 ap_rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    tick();
    ap_rst_n = 1'b1;
    repeat (5) tick();
    check("C_no_done", done_cnt, 2);

    // Frame D: hold downstream on the final beat to park in DRAIN.
    q.delete();
    start_frame();
    run_pixels(1'b0, 1'b0, 1'b1, NPIX, -1);
    repeat (5) tick();
    check("D_hold_done", int'(ap_done), 0);
    check("D_hold_done_cnt", done_cnt, 2);
    check("D_hold_in_tready", int'(in_if.TREADY), 0);
    check("D_hold_idle", int'(ap_idle), 0);
    check("D_hold_tvalid", int'(out_if.TVALID), 1);
    check("D_hold_tdata", int'(out_if.TDATA), exp_pix(NOUT - 1));
    check("D_hold_beats", q.size(), NOUT - 1);
    out_if.TREADY = 1'b1;
    wait_done(2);
    check_frame("D");
    check("D_done_after_beat", done_cyc - last_beat_cyc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
